tff_counter: RTL and testbench
==============================

# tff_counter

Synchronous modulo-N up/down counter built from a chain of toggle flip-flop cells. Each cell is a D flip-flop with d = q ^ t. The block sits directly downstream of the basic flip-flop stage: it consumes the flip-flop's q/qbar behaviour and turns it into a multi-bit count. It is the first consumer of the T-flip-flop primitive in the design.

## Interface
Parameters:
- WIDTH, 4, counter width in bits; legal range 1..16.
- MODULUS, 16, count modulus; legal range 2..2^WIDTH; the count runs 0..MODULUS-1.

Ports:
- clk  input  1  rising-edge clock; the only clock in the block.
- reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- en  input  1  count enable; when low, the count holds.
- up  input  1  direction: 1 = increment, 0 = decrement.
- load  input  1  parallel load strobe; present only with TFF_COUNTER_LOAD_EN.
- load_val  input  WIDTH  parallel load value; present only with TFF_COUNTER_LOAD_EN.
- count  output  WIDTH  current count, taken from the cell q outputs.
- count_bar  output  WIDTH  bitwise complement of count, taken from the cell qbar outputs.
- tc  output  1  terminal count, combinational.
- wrap  output  1  registered one-cycle pulse that marks a wrap-around.

## Operation
- Next-state logic computes next_count; the per-cell toggle vector is t = count ^ next_count.
- Only the cells where t = 1 toggle on the clock edge.
- Priority on each edge, highest first: reset, then load, then en, then hold.
- en=1, up=1: next_count = count+1. At count = MODULUS-1, next_count = 0.
- en=1, up=0: next_count = count-1. At count = 0, next_count = MODULUS-1.
- en=0, with no load and no reset: t = 0 and every cell holds.
- Load: next_count = load_val when load_val < MODULUS; otherwise next_count = MODULUS-1 (clamped). A load never sets wrap.
- tc = en & ((up & count==MODULUS-1) | (~up & count==0)).
- wrap is registered from tc: it is high for exactly one cycle after an enabled edge that wrapped, and it is aligned with count showing the wrapped value.
- When load and en are high together, the load wins and wrap stays 0 on that edge.
- A direction change is accepted on any edge; the new count is count±1 per the new value of up.
- count_bar always equals ~count; the bench checks this continuously.
- When MODULUS = 2^WIDTH, the wrap arithmetic reduces to natural WIDTH-bit overflow; results are identical.

## Timing
- Reset values: count = 0, count_bar = all ones, wrap = 0. With en=0, tc = 0.
- Reset asserted mid-count: count reads 0 in the cycle after the edge; wrap clears on the same edge.
- Latency from en/up/load sampled at edge k to count updated is 1 cycle (valid after edge k).
- wrap rises after the same edge at which count takes the wrapped value.
- tc follows en/up/count combinationally with no register; it is valid before the edge at which the wrap occurs.
- All inputs are sampled only on the rising edge of clk. Callers drive inputs on negedge or earlier.

## Configuration
- TFF_COUNTER_LOAD_EN defined: the load and load_val ports exist and the load priority rules above apply.
- TFF_COUNTER_LOAD_EN undefined: the load and load_val ports are removed. Priority becomes reset, then en, then hold. All other behaviour is unchanged.

## Structure
- The shared package tff_pkg holds:
  - direction constants DIR_UP = 1'b1 and DIR_DOWN = 1'b0;
  - the default width constant TFF_DEFAULT_WIDTH = 4.
- Sub-module tff_cell has ports clk, reset, t, q, qbar. It holds a single D flip-flop with d = q ^ t and synchronous reset to q = 0.
- The counter instantiates WIDTH tff_cell instances through a generate loop.
- The next-state logic, the tc logic and the wrap register live in tff_counter.

## Test plan
- Reset: hold reset=1 for 2 edges with en=1 → count=0, count_bar=4'hF, wrap=0; after release, count=1 on the first enabled edge.
- Up wrap, WIDTH=4, MODULUS=10, up=1, en=1 for 12 edges → count goes 0..9,0,1; tc high while count=9; wrap high exactly in the cycle where count=0 after 9.
- Down wrap, MODULUS=10, start at 0, up=0 → tc=1 at count 0; next count=9; wrap pulse 1 cycle.
- Hold and direction change: en=0 for 3 edges at count=5 → count stays 5 and tc=0; then up toggles 1→0 on consecutive edges → count goes 6 then 5.
- Load (macro defined): load_val=7 with load=1 and en=1 → count=7 and wrap=0; load_val=12 with MODULUS=10 → count=9 (clamped).
- Reset mid-count at count=6 with en=1 → count=0 on the next cycle and wrap=0; counting resumes from 1 on the following enabled edge.

Source files
------------

// File: rtl/tff_pkg.sv
// Shared constants for the toggle-flip-flop counter family.
package tff_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam int TFF_DEFAULT_WIDTH = 4;

endpackage

// File: rtl/tff_cell.sv
// Single toggle cell: a D flip-flop fed with q ^ t, synchronously cleared by reset.
module tff_cell (
    input  logic clk,
    input  logic reset,
    input  logic t,
    output logic q,
    output logic qbar
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= 1'b0;
        end else begin
            q <= q ^ t;
        end
    end

    assign qbar = ~q;

endmodule

// File: rtl/tff_counter.sv
// Modulo-MODULUS up/down counter assembled from a chain of tff_cell toggle cells.
// Define TFF_COUNTER_LOAD_EN to add the parallel load/load_val ports.
module tff_counter
    import tff_pkg::*;
#(
    parameter int WIDTH   = TFF_DEFAULT_WIDTH,
    parameter int MODULUS = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
`ifdef TFF_COUNTER_LOAD_EN
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
`endif
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] count_bar,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] next_count;
    logic [WIDTH-1:0] t;

    assign tc = en & (((up == DIR_UP) & (count == LAST)) |
                      ((up == DIR_DOWN) & (count == '0)));

    // Explicit wrap to LAST/0 keeps non-power-of-two moduli inside 0..MODULUS-1.
    always_comb begin
        next_count = count;
`ifdef TFF_COUNTER_LOAD_EN
        if (load) begin
            if (int'(load_val) < MODULUS) begin
                next_count = load_val;
            end else begin
                next_count = LAST;
            end
        end else
`endif
        if (en) begin
            if (up == DIR_UP) begin
                next_count = (count == LAST) ? '0 : count + WIDTH'(1);
            end else begin
                next_count = (count == '0) ? LAST : count - WIDTH'(1);
            end
        end
    end

    assign t = count ^ next_count;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        tff_cell u_cell (
            .clk  (clk),
            .reset(reset),
            .t    (t[i]),
            .q    (count[i]),
            .qbar (count_bar[i])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wrap <= 1'b0;
`ifdef TFF_COUNTER_LOAD_EN
        end else if (load) begin
            wrap <= 1'b0;
`endif
        end else begin
            wrap <= tc;
        end
    end

endmodule

// File: tb/tb_tff_counter.sv
// Self-checking bench for tff_counter (WIDTH=4, MODULUS=10) against an arithmetic model.
// Load scenarios are exercised only when TFF_COUNTER_LOAD_EN is defined.
module tb_tff_counter;

    localparam int W   = 4;
    localparam int MOD = 10;

    logic         clk = 1'b0;
    logic         reset;
    logic         en;
    logic         up;
    logic         load;
    logic [W-1:0] load_val;
    logic [W-1:0] count;
    logic [W-1:0] count_bar;
    logic         tc;
    logic         wrap;

    int compared   = 0;
    int mismatched = 0;

    int m_count = 0;
    bit m_wrap  = 1'b0;

    always #5 clk = ~clk;

    tff_counter #(.WIDTH(W), .MODULUS(MOD)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .up       (up),
`ifdef TFF_COUNTER_LOAD_EN
        .load     (load),
        .load_val (load_val),
`endif
        .count    (count),
        .count_bar(count_bar),
        .tc       (tc),
        .wrap     (wrap)
    );

    function automatic bit exp_tc();
        return en && ((up && m_count == MOD - 1) || (!up && m_count == 0));
    endfunction

    // One rising edge: the model takes the same inputs the DUT sees, then we settle on negedge.
    task automatic advance();
        @(posedge clk);
        if (reset) begin
            m_count = 0;
            m_wrap  = 1'b0;
        end else if (load) begin
            m_count = (int'(load_val) < MOD) ? int'(load_val) : MOD - 1;
            m_wrap  = 1'b0;
        end else if (en) begin
            m_wrap  = (up && m_count == MOD - 1) || (!up && m_count == 0);
            m_count = up ? (m_count + 1) % MOD : (m_count + MOD - 1) % MOD;
        end else begin
            m_wrap = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic restart_at(input int n);
        reset = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0;
        advance();
        reset = 1'b0; en = 1'b1;
        for (int i = 0; i < n; i++) advance();
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b1; up = 1'b1; load = 1'b0; load_val = '0;
        advance();
        advance();
        compared++;
        if (count !== 4'd0) begin
            mismatched++; $display("[TB] FAIL reset_count: got %0d expected 0", count);
        end
        compared++;
        if (count_bar !== 4'hF) begin
            mismatched++; $display("[TB] FAIL reset_count_bar: got %h expected f", count_bar);
        end
        compared++;
        if (wrap !== 1'b0) begin
            mismatched++; $display("[TB] FAIL reset_wrap: got %b expected 0", wrap);
        end
        en = 1'b0;
        #1;
        compared++;
        if (tc !== 1'b0) begin
            mismatched++; $display("[TB] FAIL reset_tc: got %b expected 0", tc);
        end
        reset = 1'b0; en = 1'b1;
        advance();
        compared++;
        if (count !== 4'd1) begin
            mismatched++; $display("[TB] FAIL reset_release: got %0d expected 1", count);
        end
    endtask

    task automatic test_up_wrap();
        restart_at(0);
        up = 1'b1;
        for (int i = 0; i < 12; i++) begin
            #1;
            compared++;
            if (tc !== exp_tc()) begin
                mismatched++; $display("[TB] FAIL up_tc: got %b expected %b at step %0d", tc, exp_tc(), i);
            end
            advance();
            compared++;
            if (count !== 4'(m_count) || count_bar !== ~4'(m_count) || wrap !== m_wrap) begin
                mismatched++;
                $display("[TB] FAIL up_step: got count=%0d bar=%h wrap=%b expected count=%0d bar=%h wrap=%b",
                         count, count_bar, wrap, m_count, ~4'(m_count), m_wrap);
            end
        end
        compared++;
        if (count !== 4'd2) begin
            mismatched++; $display("[TB] FAIL up_final: got %0d expected 2", count);
        end
    endtask

    task automatic test_down_wrap();
        restart_at(0);
        up = 1'b0;
        #1;
        compared++;
        if (tc !== 1'b1) begin
            mismatched++; $display("[TB] FAIL down_tc: got %b expected 1", tc);
        end
        advance();
        compared++;
        if (count !== 4'd9 || wrap !== 1'b1) begin
            mismatched++; $display("[TB] FAIL down_wrap: got count=%0d wrap=%b expected count=9 wrap=1", count, wrap);
        end
        advance();
        compared++;
        if (count !== 4'd8 || wrap !== 1'b0) begin
            mismatched++; $display("[TB] FAIL down_after: got count=%0d wrap=%b expected count=8 wrap=0", count, wrap);
        end
    endtask

    task automatic test_hold_dir();
        restart_at(5);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            compared++;
            if (tc !== 1'b0) begin
                mismatched++; $display("[TB] FAIL hold_tc: got %b expected 0", tc);
            end
            advance();
            compared++;
            if (count !== 4'd5 || count_bar !== 4'hA || wrap !== 1'b0) begin
                mismatched++; $display("[TB] FAIL hold: got count=%0d bar=%h wrap=%b expected 5/a/0", count, count_bar, wrap);
            end
        end
        en = 1'b1; up = 1'b1;
        advance();
        up = 1'b0;
        compared++;
        if (count !== 4'd6) begin
            mismatched++; $display("[TB] FAIL dir_up: got %0d expected 6", count);
        end
        advance();
        compared++;
        if (count !== 4'd5) begin
            mismatched++; $display("[TB] FAIL dir_down: got %0d expected 5", count);
        end
    endtask

`ifdef TFF_COUNTER_LOAD_EN
    task automatic test_load();
        restart_at(9);
        up = 1'b1; load = 1'b1; load_val = 4'd7;
        advance();
        compared++;
        if (count !== 4'd7 || wrap !== 1'b0) begin
            mismatched++; $display("[TB] FAIL load_7: got count=%0d wrap=%b expected 7/0", count, wrap);
        end
        load_val = 4'd12;
        advance();
        compared++;
        if (count !== 4'd9 || wrap !== 1'b0) begin
            mismatched++; $display("[TB] FAIL load_clamp: got count=%0d wrap=%b expected 9/0", count, wrap);
        end
        load_val = 4'd3;
        advance();
        load = 1'b0;
        compared++;
        if (count !== 4'd3 || wrap !== 1'b0) begin
            mismatched++; $display("[TB] FAIL load_over_tc: got count=%0d wrap=%b expected 3/0", count, wrap);
        end
    endtask
`endif

    task automatic test_reset_mid();
        restart_at(6);
        reset = 1'b1;
        advance();
        compared++;
        if (count !== 4'd0 || wrap !== 1'b0) begin
            mismatched++; $display("[TB] FAIL mid_reset: got count=%0d wrap=%b expected 0/0", count, wrap);
        end
        reset = 1'b0;
        advance();
        compared++;
        if (count !== 4'd1) begin
            mismatched++; $display("[TB] FAIL mid_resume: got %0d expected 1", count);
        end
        restart_at(9);
        reset = 1'b1;
        advance();
        reset = 1'b0;
        compared++;
        if (count !== 4'd0 || wrap !== 1'b0) begin
            mismatched++; $display("[TB] FAIL reset_at_tc: got count=%0d wrap=%b expected 0/0", count, wrap);
        end
    endtask

    task automatic test_random();
        restart_at(0);
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 31) == 0);
            en    = ($urandom_range(0, 3) != 0);
            up    = $urandom_range(0, 1) == 1;
`ifdef TFF_COUNTER_LOAD_EN
            load     = ($urandom_range(0, 9) == 0);
            load_val = 4'($urandom_range(0, 15));
`endif
            #1;
            compared++;
            if (tc !== exp_tc()) begin
                mismatched++; $display("[TB] FAIL rand_tc: got %b expected %b at cycle %0d", tc, exp_tc(), i);
            end
            advance();
            compared++;
            if (count !== 4'(m_count) || count_bar !== ~4'(m_count) || wrap !== m_wrap) begin
                mismatched++;
                $display("[TB] FAIL rand_step %0d: got count=%0d bar=%h wrap=%b expected count=%0d bar=%h wrap=%b",
                         i, count, count_bar, wrap, m_count, ~4'(m_count), m_wrap);
            end
        end
        reset = 1'b0; load = 1'b0;
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = '0;
        test_reset();
        test_up_wrap();
        test_down_wrap();
        test_hold_dir();
`ifdef TFF_COUNTER_LOAD_EN
        test_load();
`endif
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
